// File: rtl/stackmem_arbiter.sv
// Arbitrates the single-ported stack/data RAM between regfetch, execute and debug.
// Grants are issued in the same cycle. Read data returns one cycle later, tagged with its owner.
module stackmem_arbiter #(
  parameter int data_mem_size_in_bits = 30,
  parameter int dbg_starve_limit      = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rf_req,
  input  logic [data_mem_size_in_bits-1:0] rf_adr,
  output logic                             rf_gnt,
  output logic                             stall_rf,
  input  logic                             ex_req,
  input  logic                             ex_we,
  input  logic                             ex_lock,
  input  logic [data_mem_size_in_bits-1:0] ex_adr,
  input  logic [31:0]                      ex_wdata,
  output logic                             ex_gnt,
  input  logic                             dbg_req,
  input  logic                             dbg_we,
  input  logic [data_mem_size_in_bits-1:0] dbg_adr,
  input  logic [31:0]                      dbg_wdata,
  output logic                             dbg_gnt,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [data_mem_size_in_bits-1:0] mem_adr,
  output logic [31:0]                      mem_wdata,
  input  logic [31:0]                      mem_rdata,
  output logic [31:0]                      rd_data,
  output logic                             rd_valid,
  output logic [1:0]                       rd_owner
);

  typedef enum logic {ARB, LOCKED} state_t;

  localparam logic [3:0] LIMIT = 4'(dbg_starve_limit);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rd_valid_q, rd_valid_d;
  logic [1:0] rd_owner_q, rd_owner_d;

  always_comb begin
    rf_gnt  = 1'b0;
    ex_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (state_q == LOCKED) begin
        // The locked cycle belongs to execute alone, even if it does not use it.
        ex_gnt = ex_req;
      end else if (dbg_req && cnt_q == LIMIT) begin
        dbg_gnt = 1'b1;
      end else if (ex_req) begin
        ex_gnt = 1'b1;
      end else if (rf_req) begin
        rf_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = rf_gnt | ex_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    if (ex_gnt) begin
      mem_we    = ex_we;
      mem_adr   = ex_adr;
      mem_wdata = ex_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_adr   = dbg_adr;
      mem_wdata = dbg_wdata;
    end else if (rf_gnt) begin
      mem_adr   = rf_adr;
    end
  end

  assign stall_rf = rf_req & ~rf_gnt & ~rst;
  assign rd_data  = mem_rdata;
  assign rd_valid = rd_valid_q;
  assign rd_owner = rd_owner_q;

  always_comb begin
    state_d    = ARB;
    cnt_d      = 4'd0;
    rd_valid_d = mem_en & ~mem_we;
    rd_owner_d = 2'd0;
    if (state_q == ARB && ex_gnt && ex_lock && !ex_we) begin
      state_d = LOCKED;
    end
    if (dbg_req && !dbg_gnt) begin
      cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    end
    if (mem_en && !mem_we) begin
      rd_owner_d = ex_gnt ? 2'd2 : (dbg_gnt ? 2'd3 : 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      cnt_q      <= 4'd0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_stackmem_arbiter.sv
// Directed bench for stackmem_arbiter: inputs change 1ns after a rising edge,
// outputs are compared 3ns after the edge, well before the next one.
module tb_stackmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_req, ex_req, ex_we, ex_lock, dbg_req, dbg_we;
  logic [29:0] rf_adr, ex_adr, dbg_adr;
  logic [31:0] ex_wdata, dbg_wdata, mem_rdata;
  logic        rf_gnt, stall_rf, ex_gnt, dbg_gnt, mem_en, mem_we, rd_valid;
  logic [29:0] mem_adr;
  logic [31:0] mem_wdata, rd_data;
  logic [1:0]  rd_owner;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stackmem_arbiter #(.data_mem_size_in_bits(30), .dbg_starve_limit(15)) dut (
    .clk(clk), .rst(rst),
    .rf_req(rf_req), .rf_adr(rf_adr), .rf_gnt(rf_gnt), .stall_rf(stall_rf),
    .ex_req(ex_req), .ex_we(ex_we), .ex_lock(ex_lock), .ex_adr(ex_adr),
    .ex_wdata(ex_wdata), .ex_gnt(ex_gnt),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_valid(rd_valid), .rd_owner(rd_owner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_req = 0; ex_req = 0; ex_we = 0; ex_lock = 0; dbg_req = 0; dbg_we = 0;
  endtask

  initial begin
    rst = 1; idle();
    rf_adr = '0; ex_adr = '0; dbg_adr = '0; ex_wdata = '0; dbg_wdata = '0; mem_rdata = '0;

    // Everything requesting while in reset: nothing may be granted.
    rf_req = 1; ex_req = 1; dbg_req = 1; ex_adr = 30'h10;
    #2;
    check("rst_ex_gnt", {31'd0, ex_gnt}, 32'd0);
    check("rst_rf_gnt", {31'd0, rf_gnt}, 32'd0);
    check("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_stall_rf", {31'd0, stall_rf}, 32'd0);
    step(); step();
    check("rst_rd_owner", {30'd0, rd_owner}, 32'd0);
    rst = 0;
    #2;
    check("post_rst_ex_gnt", {31'd0, ex_gnt}, 32'd1);
    check("post_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("post_rst_stall_rf", {31'd0, stall_rf}, 32'd1);
    step(); idle();
    #2;
    check("ex_read_rd_valid", {31'd0, rd_valid}, 32'd1);
    check("ex_read_rd_owner", {30'd0, rd_owner}, 32'd2);

    // Lone regfetch read.
    step();
    rf_req = 1; rf_adr = 30'h1ffc;
    #2;
    check("rf_gnt", {31'd0, rf_gnt}, 32'd1);
    check("rf_mem_adr", {2'd0, mem_adr}, 32'h1ffc);
    check("rf_mem_we", {31'd0, mem_we}, 32'd0);
    step(); rf_req = 0; mem_rdata = 32'hdeadbeef;
    #2;
    check("rf_rd_valid", {31'd0, rd_valid}, 32'd1);
    check("rf_rd_owner", {30'd0, rd_owner}, 32'd1);
    check("rf_rd_data", rd_data, 32'hdeadbeef);
    check("idle_mem_en", {31'd0, mem_en}, 32'd0);

    // Execute write beats regfetch; regfetch follows.
    step();
    ex_req = 1; ex_we = 1; ex_adr = 30'h40; ex_wdata = 32'h11223344; rf_req = 1; rf_adr = 30'h80;
    #2;
    check("exrf_ex_gnt", {31'd0, ex_gnt}, 32'd1);
    check("exrf_stall_rf", {31'd0, stall_rf}, 32'd1);
    check("exrf_mem_we", {31'd0, mem_we}, 32'd1);
    check("exrf_mem_wdata", mem_wdata, 32'h11223344);
    step(); ex_req = 0; ex_we = 0;
    #2;
    check("exrf_rf_gnt", {31'd0, rf_gnt}, 32'd1);
    check("exrf_stall_rf2", {31'd0, stall_rf}, 32'd0);
    check("exrf_no_rd_valid", {31'd0, rd_valid}, 32'd0);
    step(); rf_req = 0;

    // Read-modify-write with the lock held against regfetch.
    step();
    ex_req = 1; ex_we = 0; ex_lock = 1; ex_adr = 30'h100; rf_req = 1;
    #2;
    check("rmw_rd_ex_gnt", {31'd0, ex_gnt}, 32'd1);
    step(); ex_we = 1; ex_wdata = 32'h000000ab;
    #2;
    check("rmw_wr_ex_gnt", {31'd0, ex_gnt}, 32'd1);
    check("rmw_wr_rf_gnt", {31'd0, rf_gnt}, 32'd0);
    check("rmw_wr_stall_rf", {31'd0, stall_rf}, 32'd1);
    check("rmw_wr_mem_adr", {2'd0, mem_adr}, 32'h100);
    check("rmw_rd_owner", {30'd0, rd_owner}, 32'd2);
    step(); ex_req = 0; ex_we = 0; ex_lock = 0;
    #2;
    check("rmw_rf_gnt3", {31'd0, rf_gnt}, 32'd1);
    step(); rf_req = 0;

    // Debug starvation: forced slot on the 16th cycle.
    step();
    ex_req = 1; ex_we = 1; dbg_req = 1; dbg_we = 0; dbg_adr = 30'h2a;
    for (int c = 1; c <= 16; c++) begin
      #2;
      if (c == 16) begin
        check("starve_dbg_gnt16", {30'd0, dbg_gnt, ex_gnt}, 32'd2);
      end else begin
        check($sformatf("starve_ex_gnt%0d", c), {30'd0, dbg_gnt, ex_gnt}, 32'd1);
      end
      step();
    end
    #2;
    check("starve_cnt_cleared", {28'd0, dut.cnt_q}, 32'd0);
    check("starve_ex_after", {30'd0, dbg_gnt, ex_gnt}, 32'd1);
    check("starve_dbg_rd_owner", {30'd0, rd_owner}, 32'd3);
    step(); idle();

    // Reset during the locked cycle.
    step();
    ex_req = 1; ex_we = 0; ex_lock = 1; ex_adr = 30'h200;
    #2;
    check("rstlock_ex_gnt", {31'd0, ex_gnt}, 32'd1);
    step(); rst = 1; ex_we = 1;
    #2;
    check("rstlock_no_gnt", {31'd0, ex_gnt}, 32'd0);
    step(); rst = 0; idle(); rf_req = 1; rf_adr = 30'h300;
    #2;
    check("rstlock_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rstlock_rf_gnt", {31'd0, rf_gnt}, 32'd1);
    step(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stackmem_arbiter.md
# stackmem_arbiter

Shares the single-ported stack/data memory between three requesters: the register-fetch stage read port, the execute stage (load/store, including read-modify-write for storeb/storeh) and the debug port. Sits between the pipeline stages and the data RAM. Issues at most one memory access per cycle, returns tagged read data one cycle later, and produces the register-fetch stall term when that stage loses arbitration.

## Interface
Parameters:
- data_mem_size_in_bits, 30: address width of all address ports.
- dbg_starve_limit, 15: cycles the debug port may wait before it is forced a slot; 4-bit counter, legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- rf_req  in  1  regfetch read request.
- rf_adr  in  data_mem_size_in_bits  regfetch read address.
- rf_gnt  out  1  regfetch granted this cycle.
- stall_rf  out  1  rf_req & ~rf_gnt; ORed into the regfetch stall.
- ex_req / ex_we / ex_lock  in  1 each  execute request, write enable, hold port for the following cycle.
- ex_adr  in  data_mem_size_in_bits;  ex_wdata  in  32.
- ex_gnt  out  1  execute granted this cycle.
- dbg_req / dbg_we  in  1 each;  dbg_adr  in  data_mem_size_in_bits;  dbg_wdata  in  32.
- dbg_gnt  out  1  debug granted this cycle.
- mem_en / mem_we  out  1 each;  mem_adr  out  data_mem_size_in_bits;  mem_wdata  out  32.
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en & ~mem_we.
- rd_data  out  32  mem_rdata passed through.
- rd_valid  out  1  rd_data valid this cycle.
- rd_owner  out  2  0=none, 1=rf, 2=ex, 3=dbg.

## Operation
- Registered state: fsm {ARB, LOCKED}, starve counter cnt (4 bit), rd_valid, rd_owner.
- Grants are combinational from requests and registered state; exactly zero or one gnt high per cycle.
- ARB priority, highest first:
  - dbg, if dbg_req & cnt == dbg_starve_limit;
  - ex, if ex_req;
  - rf, if rf_req;
  - dbg, if dbg_req.
- LOCKED: ex_gnt = ex_req; rf and dbg are not granted. If ex_req is low in LOCKED, no access is issued.
- FSM transitions:
  - ARB -> LOCKED when ex_gnt & ex_lock & ~ex_we.
  - LOCKED -> ARB unconditionally after one cycle. The lock always covers exactly one following cycle; ex_lock in LOCKED is ignored.
- Starvation counter:
  - cnt increments (saturating at 15) when dbg_req & ~dbg_gnt;
  - cnt clears when dbg_gnt or ~dbg_req.
- mem_en = any gnt.
- mem_we, mem_adr and mem_wdata are muxed from the granted requester. rf is read-only: mem_we = 0 for an rf grant.
- With no grant: mem_adr = 0, mem_wdata = 0, mem_we = 0.
- Read return: on a granted read, next cycle rd_valid = 1 and rd_owner = the granted requester. Writes produce no rd_valid.
- rd_data is combinationally mem_rdata; consumers must qualify it with rd_valid and rd_owner.

## Timing
- Reset values:
  - fsm = ARB, cnt = 0, rd_valid = 0, rd_owner = 0.
  - All gnt, stall_rf, mem_en and mem_we are 0 while rst is high, regardless of requests.
- Grant latency 0 cycles (same-cycle Mealy grant); read data latency 1 cycle; throughput 1 access per cycle.
- Requesters hold req, adr and data stable until they see gnt high at a clock edge.
- Back-to-back reads from different owners give back-to-back rd_valid with correct rd_owner each cycle.
- Reset asserted in LOCKED: next state is ARB, and any pending rd_valid is dropped (rd_valid = 0 the cycle after the reset edge).
- Simultaneous ex_req, rf_req and dbg_req with cnt < limit: ex wins; cnt increments.

## Test plan
- Reset: all requests high during rst -> all gnt = 0, mem_en = 0; first cycle after rst, ex_gnt = 1 and rd_valid = 0.
- rf read alone at 0x1ffc, mem_rdata = 0xdeadbeef -> rf_gnt the same cycle, mem_adr = 0x1ffc; next cycle rd_valid = 1, rd_owner = 1, rd_data = 0xdeadbeef.
- ex and rf request together -> ex_gnt = 1, stall_rf = 1; next cycle (ex_req low) rf_gnt = 1, stall_rf = 0.
- storeb RMW:
  - ex read 0x100 with ex_lock while rf_req is held -> LOCKED; the following ex write 0x100 is granted and rf is denied.
  - rf is granted on the third cycle.
- Debug starvation: ex_req and dbg_req held high 16 cycles -> dbg_gnt exactly on cycle 16 (cnt = 15), ex_gnt on all other cycles, cnt = 0 after the grant.
- Reset mid-lock: assert rst in the LOCKED cycle -> fsm = ARB and rd_valid = 0 after the edge; an rf_req in the next cycle is granted.
